// File: rtl/ladybird_hazard_unit.sv
// ladybird_hazard_unit: register-write scoreboard with RAW stall and same-cycle retire bypass.
// Optional LADYBIRD_HAZARD_STATS_EN adds a saturating stall_cycles counter.
module ladybird_hazard_unit #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int MAX_INFLIGHT = 4,
  localparam int RW = $clog2(NREG),
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [RW-1:0]   issue_rs1,
  input  logic [RW-1:0]   issue_rs2,
  input  logic            issue_use_rs1,
  input  logic            issue_use_rs2,
  input  logic [RW-1:0]   issue_rd,
  input  logic            issue_rd_we,
  input  logic            retire_valid,
  input  logic [RW-1:0]   retire_rd,
  input  logic            retire_we,
  input  logic [XLEN-1:0] retire_data,
  output logic            fwd_rs1_sel,
  output logic [XLEN-1:0] fwd_rs1_data,
  output logic            fwd_rs2_sel,
  output logic [XLEN-1:0] fwd_rs2_data,
  input  logic            flush,
  output logic [CW-1:0]   inflight,
`ifdef LADYBIRD_HAZARD_STATS_EN
  output logic [31:0]     stall_cycles,
`endif
  output logic            idle,
  output logic            underflow_err
);
  logic [CW-1:0] r_cnt [NREG];
  logic [CW-1:0] r_inflight;
  logic          r_underflow;
  logic          w_ret, w_iss, w_dec, w_hit1, w_hit2, w_blk1, w_blk2, w_rd_full;
  always_comb begin
    w_ret     = retire_valid & retire_we & (retire_rd != '0);
    w_hit1    = w_ret & (retire_rd == issue_rs1) & (r_cnt[issue_rs1] == CW'(1));
    w_hit2    = w_ret & (retire_rd == issue_rs2) & (r_cnt[issue_rs2] == CW'(1));
    w_blk1    = issue_use_rs1 & (issue_rs1 != '0) & (r_cnt[issue_rs1] != '0) & ~w_hit1;
    w_blk2    = issue_use_rs2 & (issue_rs2 != '0) & (r_cnt[issue_rs2] != '0) & ~w_hit2;
    w_rd_full = issue_rd_we & (issue_rd != '0) & (r_cnt[issue_rd] == CW'(MAX_INFLIGHT));
    // a retire in the same cycle frees a slot, so a full scoreboard may still accept
    issue_ready = nrst & ~flush & ~w_blk1 & ~w_blk2 & ~w_rd_full &
                  ((r_inflight < CW'(MAX_INFLIGHT)) | w_ret);
    w_iss = issue_valid & issue_ready & issue_rd_we & (issue_rd != '0);
    w_dec = w_ret & (r_cnt[retire_rd] != '0);
    fwd_rs1_sel  = w_hit1;
    fwd_rs2_sel  = w_hit2;
    fwd_rs1_data = w_hit1 ? retire_data : '0;
    fwd_rs2_data = w_hit2 ? retire_data : '0;
    inflight      = r_inflight;
    idle          = (r_inflight == '0);
    underflow_err = r_underflow;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
      r_inflight  <= '0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
      r_inflight <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        r_cnt[r] <= r_cnt[r] + CW'(w_iss && issue_rd == RW'(r)) - CW'(w_dec && retire_rd == RW'(r));
      r_inflight <= r_inflight + CW'(w_iss) - CW'(w_dec);
      if (w_ret && !w_dec) r_underflow <= 1'b1;
    end
  end
`ifdef LADYBIRD_HAZARD_STATS_EN
  logic [31:0] r_stall;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_stall <= '0;
    else if (issue_valid && !issue_ready && !flush && r_stall != 32'hFFFF_FFFF) r_stall <= r_stall + 32'd1;
  end
  assign stall_cycles = r_stall;
`endif
endmodule

// File: tb/tb_ladybird_hazard_unit.sv
// tb_ladybird_hazard_unit: directed scoreboard bench for ladybird_hazard_unit.
module tb_ladybird_hazard_unit;
  logic        clk = 1'b0, nrst = 1'b0;
  logic        issue_valid, issue_ready, issue_use_rs1, issue_use_rs2, issue_rd_we;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, retire_rd;
  logic        retire_valid, retire_we, flush;
  logic [31:0] retire_data, fwd_rs1_data, fwd_rs2_data;
  logic        fwd_rs1_sel, fwd_rs2_sel, idle, underflow_err;
  logic [2:0]  inflight;
`ifdef LADYBIRD_HAZARD_STATS_EN
  logic [31:0] stall_cycles;
`endif
  ladybird_hazard_unit dut (
    .clk(clk), .nrst(nrst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
    .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_we(retire_we), .retire_data(retire_data),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs1_data(fwd_rs1_data),
    .fwd_rs2_sel(fwd_rs2_sel), .fwd_rs2_data(fwd_rs2_data),
    .flush(flush), .inflight(inflight),
`ifdef LADYBIRD_HAZARD_STATS_EN
    .stall_cycles(stall_cycles),
`endif
    .idle(idle), .underflow_err(underflow_err)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [15:0] id;
    logic        rdy;
    logic        s1;
    logic [31:0] d1;
    logic        s2;
    logic [31:0] d2;
    logic [2:0]  infl;
    logic        idl;
    logic        uf;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0, step_id = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask
  task automatic drv(input logic iv, input int rs1, input logic u1, input int rs2, input logic u2,
                     input int rd, input logic we, input logic rv, input int rrd, input logic rwe,
                     input logic [31:0] rdata, input logic fl);
    issue_valid = iv; issue_rs1 = 5'(rs1); issue_use_rs1 = u1; issue_rs2 = 5'(rs2); issue_use_rs2 = u2;
    issue_rd = 5'(rd); issue_rd_we = we; retire_valid = rv; retire_rd = 5'(rrd); retire_we = rwe;
    retire_data = rdata; flush = fl;
  endtask
  task automatic step(input logic rdy, input logic s1, input logic [31:0] d1, input logic s2,
                      input logic [31:0] d2, input logic [2:0] infl, input logic idl, input logic uf);
    exp_t e;
    step_id++;
    q.push_back('{id: 16'(step_id), rdy: rdy, s1: s1, d1: d1, s2: s2, d2: d2, infl: infl, idl: idl, uf: uf});
    @(negedge clk);
    e = q.pop_front();
    chk($sformatf("s%0d issue_ready", e.id), 32'(issue_ready), 32'(e.rdy));
    chk($sformatf("s%0d fwd_rs1_sel", e.id), 32'(fwd_rs1_sel), 32'(e.s1));
    chk($sformatf("s%0d fwd_rs1_data", e.id), fwd_rs1_data, e.d1);
    chk($sformatf("s%0d fwd_rs2_sel", e.id), 32'(fwd_rs2_sel), 32'(e.s2));
    chk($sformatf("s%0d fwd_rs2_data", e.id), fwd_rs2_data, e.d2);
    chk($sformatf("s%0d inflight", e.id), 32'(inflight), 32'(e.infl));
    chk($sformatf("s%0d idle", e.id), 32'(idle), 32'(e.idl));
    chk($sformatf("s%0d underflow_err", e.id), 32'(underflow_err), 32'(e.uf));
    @(posedge clk);
    #1;
  endtask
  initial begin
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
`ifdef LADYBIRD_HAZARD_STATS_EN
    chk("reset stall_cycles", stall_cycles, 0);
`endif
    nrst = 1'b1;
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 32'h55, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    drv(1, 0, 0, 5, 1, 0, 0, 1, 5, 1, 32'hDEADBEEF, 0);
    step(1, 0, 0, 1, 32'hDEADBEEF, 1, 0, 0);
    drv(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0, 0, 1, 0);
    drv(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    for (int r = 1; r <= 4; r++) begin
      drv(1, 0, 0, 0, 0, r, 1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 3'(r - 1), r == 1, 0);
    end
    drv(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 4, 0, 0);
    drv(1, 0, 0, 0, 0, 6, 1, 1, 1, 1, 32'h1234, 0);
    step(1, 0, 0, 0, 0, 4, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 4, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 32'h22, 0);
    step(1, 0, 0, 0, 0, 4, 0, 0);
    drv(1, 0, 0, 0, 0, 7, 1, 1, 3, 1, 32'h33, 1);
    step(0, 0, 0, 0, 0, 3, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 32'h77, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    drv(1, 3, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 1);
    nrst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 1, 0);
    nrst = 1'b1;
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef LADYBIRD_HAZARD_STATS_EN
    chk("stall_cycles after 10 blocked", stall_cycles, 10);
`endif
    step(1, 0, 0, 0, 0, 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ladybird_hazard_unit.md
Name: ladybird_hazard_unit

Overview:
Parametrised scoreboard and operand-bypass unit for the next-generation ladybird pipeline, which adds real stall generation.
- Tracks outstanding register writes between issue (decode/exec boundary) and retire (commit/writeback).
- Blocks issue on RAW hazards, per-register overflow and total in-flight overflow.
- Forwards same-cycle retire data to the issuing instruction.
- Drives the pipeline_stall input of the core and replaces the hard-wired no-stall.

Parameters:
XLEN, 32, data width of retire/bypass data
NREG, 32, number of architectural registers; register 0 is hard-wired zero and never tracked
MAX_INFLIGHT, 4, max outstanding writes per register and in total; counter width CW = $clog2(MAX_INFLIGHT+1)

Ports:
clk  input  1  clock, rising edge
nrst  input  1  reset, asynchronous assert, active-low
issue_valid  input  1  instruction presented for issue
issue_ready  output  1  issue accepted this cycle when issue_valid & issue_ready
issue_rs1  input  $clog2(NREG)  source register 1
issue_rs2  input  $clog2(NREG)  source register 2
issue_use_rs1  input  1  instruction reads rs1
issue_use_rs2  input  1  instruction reads rs2
issue_rd  input  $clog2(NREG)  destination register
issue_rd_we  input  1  instruction writes rd
retire_valid  input  1  an instruction retires this cycle
retire_rd  input  $clog2(NREG)  retiring destination
retire_we  input  1  retiring instruction writes rd
retire_data  input  XLEN  value being written back
fwd_rs1_sel  output  1  use fwd_rs1_data instead of the GPR read
fwd_rs1_data  output  XLEN  bypass value for rs1
fwd_rs2_sel  output  1  use fwd_rs2_data instead of the GPR read
fwd_rs2_data  output  XLEN  bypass value for rs2
flush  input  1  discard all in-flight tracking (branch redirect or trap)
inflight  output  CW  total outstanding tracked writes
idle  output  1  inflight == 0
underflow_err  output  1  sticky: a tracked retire hit a zero counter

Behaviour:
- Reset (nrst low, async): all per-register counters = 0, inflight = 0, underflow_err = 0.
- Outputs during reset: issue_ready = 0, idle = 1, fwd_*_sel = 0, fwd_*_data = 0.
- State: cnt[r] (CW bits) for r = 1..NREG-1; cnt[0] is constant 0. Writes to x0 are never counted.
- Tracked retire: retire_valid & retire_we & retire_rd != 0.
- Tracked issue: issue_valid & issue_ready & issue_rd_we & issue_rd != 0.
- Operand rsN (N = 1, 2) is blocked when use_rsN & rsN != 0 & cnt[rsN] != 0. Exception: bypass hit.
  - Bypass hit: cnt[rsN] == 1 & tracked retire & retire_rd == rsN.
  - On a bypass hit: fwd_rsN_sel = 1 and fwd_rsN_data = retire_data (combinational, same cycle).
  - Otherwise: fwd_rsN_sel = 0 and fwd_rsN_data = 0.
- issue_ready = nrst & ~flush & ~blocked_rs1 & ~blocked_rs2 & ~(issue_rd_we & issue_rd != 0 & cnt[issue_rd] == MAX_INFLIGHT) & (inflight < MAX_INFLIGHT | tracked retire).
  - issue_ready has no combinational dependence on issue_valid.
- Counter update, registered at the next edge:
  - cnt[rd] += 1 on a tracked issue.
  - cnt[retire_rd] -= 1 on a tracked retire.
  - Same register issued and retired in one cycle: count unchanged.
  - inflight tracks the sum of all counters by the same rule.
- Underflow: a tracked retire with cnt[retire_rd] == 0 leaves counters unchanged, does not decrement inflight, and sets underflow_err until reset.
- Flush has priority over both issue and retire:
  - At the next edge all counters and inflight = 0.
  - issue_ready = 0 during the flush cycle; retires in that cycle are dropped.
  - underflow_err is preserved.
- Latency:
  - Hazard/bypass decision: 0 cycles (combinational from issue/retire inputs and the registered counters).
  - Counter effect: visible 1 cycle after the event.
- Counters never wrap; overflow is prevented by the issue_ready conditions.

Optional Feature:
LADYBIRD_HAZARD_STATS_EN
- Defined: adds output stall_cycles (32 bits), reset 0.
  - Increments each cycle with issue_valid & ~issue_ready & ~flush.
  - Saturates at 32'hFFFF_FFFF and is cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release; issue rd=5 (we=1), then the next cycle issue rs1=5 with no retire -> issue_ready=0, inflight=1; cycle after retire(5) -> issue_ready=1, fwd_rs1_sel=0.
- cnt[5]=1; same cycle retire_rd=5, retire_data=32'hDEADBEEF, issue rs2=5 -> issue_ready=1, fwd_rs2_sel=1, fwd_rs2_data=32'hDEADBEEF; next cycle cnt[5]=0.
- Issue rd=0 with we=1 four times, then use_rs1=1, rs1=0 -> inflight stays 0, issue_ready=1 throughout.
- Issue writes to x1, x2, x3, x4 (inflight=4), then a 5th issue rd=6 -> issue_ready=0; same cycle as a retire(x1) -> issue_ready=1 and inflight stays 4.
- inflight=3 with flush=1 and a concurrent retire -> issue_ready=0 that cycle; next cycle inflight=0, idle=1, underflow_err=0.
- Retire rd=7 with cnt[7]=0 -> underflow_err=1, inflight unchanged; with LADYBIRD_HAZARD_STATS_EN, 10 blocked valid cycles -> stall_cycles=10.
